// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and defaults for the branch hazard controller
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    BHC_IDLE  = 1'b0,
    BHC_STALL = 1'b1
  } bhc_state_t;

endpackage

// File: rtl/bhc_src_resolve.sv
// rtl/bhc_src_resolve.sv - per-source bypass select, operand data and stall need
module bhc_src_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int RA_W = riscv_pkg::RA_W
) (
  input  logic            chk,
  input  logic [RA_W-1:0] rs,
  input  logic            ex_reg_rw,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_reg_rw,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_rw,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] mem_alu_data,
  input  logic [XLEN-1:0] wb_data,
  output fwd_sel_t        sel,
  output logic [XLEN-1:0] data,
  output logic [1:0]      need
);

  logic nz, ex_hit, mem_hit, wb_hit;

  assign nz      = |rs;
  assign ex_hit  = nz & ex_reg_rw  & (ex_rd  == rs);
  assign mem_hit = nz & mem_reg_rw & (mem_rd == rs);
  assign wb_hit  = nz & wb_reg_rw  & (wb_rd  == rs);

  // A load in MEM has no data yet, so it falls through to WB/RF while stalling.
  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (mem_hit && !mem_mem_read) begin
      sel  = FWD_MEM;
      data = mem_alu_data;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

  always_comb begin
    need = 2'd0;
    if (chk) begin
      if (ex_hit)                     need = ex_mem_read ? 2'd2 : 2'd1;
      else if (mem_hit && mem_mem_read) need = 2'd1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - decode-stage branch hazard controller; BRANCH_HAZ_STATS_EN adds stall/flush counters
module branch_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int RA_W   = riscv_pkg::RA_W,
  parameter int STAT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_branch,
  input  logic            id_jalr,
  input  logic            id_jal,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_reg_rw,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_reg_rw,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_reg_rw,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic [XLEN-1:0] mem_alu_data,
  input  logic [XLEN-1:0] wb_data,
  input  logic            cmp_taken,
  input  logic            kill,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  output logic [1:0]      fwd_rs1_sel,
  output logic [1:0]      fwd_rs2_sel,
  output logic            stall,
  output logic            ex_bubble,
  output logic            flush_if,
  output logic            busy
`ifdef BRANCH_HAZ_STATS_EN
  , output logic [STAT_W-1:0] stat_stall_cyc
  , output logic [STAT_W-1:0] stat_flush_cnt
`endif
);

  logic       ctl;
  logic [1:0] need1, need2, need;
  fwd_sel_t   sel1, sel2;
  bhc_state_t state;
  logic [1:0] cnt;
  logic       hazard;

  assign ctl = id_valid & (id_branch | id_jalr);

  bhc_src_resolve #(.XLEN(XLEN), .RA_W(RA_W)) u_rs1 (
    .chk(ctl), .rs(id_rs1),
    .ex_reg_rw(ex_reg_rw), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_rw(mem_reg_rw), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_rw(wb_reg_rw), .wb_rd(wb_rd),
    .rf_data(rf_rs1_data), .mem_alu_data(mem_alu_data), .wb_data(wb_data),
    .sel(sel1), .data(cmp_a), .need(need1)
  );

  bhc_src_resolve #(.XLEN(XLEN), .RA_W(RA_W)) u_rs2 (
    .chk(ctl & id_branch), .rs(id_rs2),
    .ex_reg_rw(ex_reg_rw), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_rw(mem_reg_rw), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_rw(wb_reg_rw), .wb_rd(wb_rd),
    .rf_data(rf_rs2_data), .mem_alu_data(mem_alu_data), .wb_data(wb_data),
    .sel(sel2), .data(cmp_b), .need(need2)
  );

  assign fwd_rs1_sel = sel1;
  assign fwd_rs2_sel = sel2;
  assign need        = (need1 > need2) ? need1 : need2;
  assign hazard      = (need != 2'd0) & ~kill;

  // The Mealy detection cycle is the first stall cycle, so only the
  // remaining need-1 cycles are held in STALL (cnt counts the extras).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BHC_IDLE;
      cnt   <= 2'd0;
    end else if (kill) begin
      state <= BHC_IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        BHC_IDLE: begin
          if (need > 2'd1) begin
            state <= BHC_STALL;
            cnt   <= need - 2'd2;
          end
        end
        BHC_STALL: begin
          if (cnt == 2'd0) state <= BHC_IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        default: begin
          state <= BHC_IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  assign busy      = (state == BHC_STALL);
  assign stall     = ((state == BHC_IDLE) & hazard) | busy;
  assign ex_bubble = stall;
  assign flush_if  = id_valid & ~stall & ~kill & (id_jal | id_jalr | (id_branch & cmp_taken));

`ifdef BRANCH_HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_stall_cyc <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (stall && !(&stat_stall_cyc))    stat_stall_cyc <= stat_stall_cyc + 1'b1;
      if (flush_if && !(&stat_flush_cnt)) stat_flush_cnt <= stat_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - directed self-checking bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_branch, id_jalr, id_jal;
  logic [4:0]  id_rs1, id_rs2;
  logic        ex_reg_rw, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_reg_rw, mem_mem_read;
  logic [4:0]  mem_rd;
  logic        wb_reg_rw;
  logic [4:0]  wb_rd;
  logic [31:0] rf_rs1_data, rf_rs2_data, mem_alu_data, wb_data;
  logic        cmp_taken, kill;
  logic [31:0] cmp_a, cmp_b;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        stall, ex_bubble, flush_if, busy;
`ifdef BRANCH_HAZ_STATS_EN
  logic [3:0]  stat_stall_cyc, stat_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.STAT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_branch(id_branch), .id_jalr(id_jalr), .id_jal(id_jal),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_reg_rw(ex_reg_rw), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_rw(mem_reg_rw), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_rw(wb_reg_rw), .wb_rd(wb_rd),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_alu_data(mem_alu_data), .wb_data(wb_data),
    .cmp_taken(cmp_taken), .kill(kill),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall(stall), .ex_bubble(ex_bubble), .flush_if(flush_if), .busy(busy)
`ifdef BRANCH_HAZ_STATS_EN
    , .stat_stall_cyc(stat_stall_cyc), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; id_branch = 0; id_jalr = 0; id_jal = 0;
    id_rs1 = 0; id_rs2 = 0;
    ex_reg_rw = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_rw = 0; mem_mem_read = 0; mem_rd = 0;
    wb_reg_rw = 0; wb_rd = 0;
    rf_rs1_data = 0; rf_rs2_data = 0; mem_alu_data = 0; wb_data = 0;
    cmp_taken = 0; kill = 0;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_bubble"}, 32'(ex_bubble), 32'd0);
    check({tag, "_flush"}, 32'(flush_if), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sel1"}, 32'(fwd_rs1_sel), 32'd0);
    check({tag, "_sel2"}, 32'(fwd_rs2_sel), 32'd0);
  endtask

  initial begin
    rst_n = 0;
    clr();
    tick(); tick();
    check_idle_outs("reset");
    rst_n = 1;

    // EX ALU producer -> branch: one stall cycle, then MEM bypass
    tick(); clr();
    id_valid = 1; id_branch = 1; id_rs1 = 5; id_rs2 = 9;
    ex_reg_rw = 1; ex_rd = 5; mem_alu_data = 32'h1111_2222; rf_rs1_data = 32'hAAAA_0000;
    cmp_taken = 1;
    #1;
    check("alu_c0_stall", 32'(stall), 32'd1);
    check("alu_c0_bubble", 32'(ex_bubble), 32'd1);
    check("alu_c0_flush", 32'(flush_if), 32'd0);
    tick();
    ex_reg_rw = 0; ex_rd = 0; mem_reg_rw = 1; mem_rd = 5;
    #1;
    check("alu_c1_stall", 32'(stall), 32'd0);
    check("alu_c1_busy", 32'(busy), 32'd0);
    check("alu_c1_sel1", 32'(fwd_rs1_sel), 32'd1);
    check("alu_c1_cmp_a", cmp_a, 32'h1111_2222);
    check("alu_c1_flush", 32'(flush_if), 32'd1);

    // EX load -> branch rs2: two stall cycles, then WB bypass
    tick(); clr();
    id_valid = 1; id_branch = 1; id_rs1 = 1; id_rs2 = 7;
    ex_reg_rw = 1; ex_mem_read = 1; ex_rd = 7;
    wb_data = 32'h3333_4444; rf_rs2_data = 32'hBBBB_0000; cmp_taken = 1;
    #1;
    check("ld_c0_stall", 32'(stall), 32'd1);
    check("ld_c0_flush", 32'(flush_if), 32'd0);
    tick();
    ex_reg_rw = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_rw = 1; mem_mem_read = 1; mem_rd = 7;
    #1;
    check("ld_c1_stall", 32'(stall), 32'd1);
    check("ld_c1_busy", 32'(busy), 32'd1);
    check("ld_c1_flush", 32'(flush_if), 32'd0);
    tick();
    mem_reg_rw = 0; mem_mem_read = 0; mem_rd = 0; wb_reg_rw = 1; wb_rd = 7;
    #1;
    check("ld_c2_stall", 32'(stall), 32'd0);
    check("ld_c2_busy", 32'(busy), 32'd0);
    check("ld_c2_sel2", 32'(fwd_rs2_sel), 32'd2);
    check("ld_c2_cmp_b", cmp_b, 32'h3333_4444);

    // MEM and WB both write rd=3: MEM wins, no stall; rd=0 never matches
    tick(); clr();
    id_valid = 1; id_branch = 1; id_rs1 = 3; id_rs2 = 3;
    mem_reg_rw = 1; mem_rd = 3; wb_reg_rw = 1; wb_rd = 3;
    mem_alu_data = 32'h5555_5555; wb_data = 32'h6666_6666;
    rf_rs1_data = 32'h10; rf_rs2_data = 32'h20;
    #1;
    check("prio_sel1", 32'(fwd_rs1_sel), 32'd1);
    check("prio_sel2", 32'(fwd_rs2_sel), 32'd1);
    check("prio_stall", 32'(stall), 32'd0);
    check("prio_cmp_b", cmp_b, 32'h5555_5555);
    id_rs1 = 0; id_rs2 = 0; mem_rd = 0; wb_rd = 0;
    #1;
    check("x0_sel1", 32'(fwd_rs1_sel), 32'd0);
    check("x0_sel2", 32'(fwd_rs2_sel), 32'd0);
    check("x0_cmp_a", cmp_a, 32'h10);
    check("x0_cmp_b", cmp_b, 32'h20);

    // unconditional and not-taken control transfers
    tick(); clr();
    id_valid = 1; id_jal = 1;
    #1;
    check("jal_flush", 32'(flush_if), 32'd1);
    check("jal_stall", 32'(stall), 32'd0);
    id_jal = 0; id_branch = 1; id_rs1 = 2; cmp_taken = 0;
    #1;
    check("bnt_flush", 32'(flush_if), 32'd0);
    id_branch = 0; id_jalr = 1;
    #1;
    check("jalr_flush", 32'(flush_if), 32'd1);
    // rs2 ignored for JALR even when it hits an EX load
    id_rs2 = 4; ex_reg_rw = 1; ex_mem_read = 1; ex_rd = 4;
    #1;
    check("jalr_rs2_stall", 32'(stall), 32'd0);

    // kill together with a new hazard: kill wins
    tick(); clr();
    id_valid = 1; id_branch = 1; id_rs1 = 5;
    ex_reg_rw = 1; ex_mem_read = 1; ex_rd = 5; kill = 1; cmp_taken = 1;
    #1;
    check("killhz_stall", 32'(stall), 32'd0);
    check("killhz_flush", 32'(flush_if), 32'd0);
    tick(); clr();
    #1;
    check("killhz_busy", 32'(busy), 32'd0);

    // kill in 2nd cycle of a load stall
    tick(); clr();
    id_valid = 1; id_branch = 1; id_rs1 = 6;
    ex_reg_rw = 1; ex_mem_read = 1; ex_rd = 6;
    #1;
    check("killst_c0_stall", 32'(stall), 32'd1);
    tick();
    ex_reg_rw = 0; ex_mem_read = 0; ex_rd = 0;
    mem_reg_rw = 1; mem_mem_read = 1; mem_rd = 6; kill = 1;
    #1;
    check("killst_c1_busy", 32'(busy), 32'd1);
    tick(); clr();
    #1;
    check("killst_c2_stall", 32'(stall), 32'd0);
    check("killst_c2_busy", 32'(busy), 32'd0);

    // reset mid-stall
    tick(); clr();
    id_valid = 1; id_branch = 1; id_rs2 = 8;
    ex_reg_rw = 1; ex_mem_read = 1; ex_rd = 8;
    #1;
    check("rstst_c0_stall", 32'(stall), 32'd1);
    tick();
    check("rstst_c1_busy", 32'(busy), 32'd1);
    rst_n = 0; clr();
    tick();
    #1;
    check_idle_outs("rstst");
    rst_n = 1;

`ifdef BRANCH_HAZ_STATS_EN
    rst_n = 0; tick(); rst_n = 1;
    id_valid = 1; id_branch = 1; id_rs1 = 5; ex_reg_rw = 1; ex_rd = 5;
    repeat (20) tick();
    clr();
    #1;
    check("stat_stall_sat", 32'(stat_stall_cyc), 32'd15);
    check("stat_flush_zero", 32'(stat_flush_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
